// File: rtl/regfile_dbg_pkg.sv
// Shared constants for the register-file debug dump frame.
// Used by the dump controller and the host-side frame checker.
package regfile_dbg_pkg;

  localparam int NUM_REGS_D = 16;
  localparam int ADDR_W_D   = 4;
  localparam int DATA_W_D   = 16;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_HI    = 3'd3;
  localparam logic [2:0] ST_LO    = 3'd4;
  localparam logic [2:0] ST_SUM   = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    HDR   = ST_HDR,
    FETCH = ST_FETCH,
    HI    = ST_HI,
    LO    = ST_LO,
    SUM   = ST_SUM
  } state_t;

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Byte stream with valid/ready handshake.
// Master drives data/valid, slave drives ready.
interface regfile_dump_ctrl_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file and streams a framed dump:
// A5, hi/lo byte per register, XOR checksum of data bytes.
module regfile_dump_ctrl
  import regfile_dbg_pkg::*;
#(
  parameter int         NUM_REGS = NUM_REGS_D,
  parameter int         ADDR_W   = ADDR_W_D,
  parameter int         DATA_W   = DATA_W_D,
  parameter logic [7:0] HEADER   = HEADER_BYTE
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  regfile_dump_ctrl_if.master stream,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idxNext;
  logic [7:0]        csum;
  logic [7:0]        csumNext;
  logic [7:0]        dataQ;
  logic [7:0]        dataNext;
  logic [DATA_W-1:0] wordQ;
  logic [DATA_W-1:0] wordNext;
  logic              validQ;
  logic              validNext;
  logic              busyQ;
  logic              busyNext;
  logic              doneQ;
  logic              doneNext;
  logic              xfer;

  assign xfer             = validQ & stream.out_ready;
  assign rd_addr          = idx;
  assign busy             = busyQ;
  assign cpu_stall        = busyQ;
  assign done             = doneQ;
  assign stream.out_data  = dataQ;
  assign stream.out_valid = validQ;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      idx    <= '0;
      csum   <= '0;
      dataQ  <= '0;
      wordQ  <= '0;
      validQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      idx    <= idxNext;
      csum   <= csumNext;
      dataQ  <= dataNext;
      wordQ  <= wordNext;
      validQ <= validNext;
      busyQ  <= busyNext;
      doneQ  <= doneNext;
    end
  end

  // Outputs are computed one state ahead so they leave as registers.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    csumNext  = csum;
    dataNext  = dataQ;
    wordNext  = wordQ;
    validNext = validQ;
    busyNext  = busyQ;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          stateNext = HDR;
          idxNext   = '0;
          csumNext  = '0;
          dataNext  = HEADER;
          validNext = 1'b1;
          busyNext  = 1'b1;
        end
      end
      HDR: begin
        if (xfer) begin
          stateNext = FETCH;
          validNext = 1'b0;
        end
      end
      FETCH: begin
        wordNext  = rd_data;
        dataNext  = rd_data[15:8];
        validNext = 1'b1;
        stateNext = HI;
      end
      HI: begin
        if (xfer) begin
          csumNext  = csum ^ dataQ;
          dataNext  = wordQ[7:0];
          stateNext = LO;
        end
      end
      LO: begin
        if (xfer) begin
          csumNext = csum ^ dataQ;
          if (idx == LAST_IDX) begin
            dataNext  = csumNext;
            stateNext = SUM;
          end else begin
            idxNext   = idx + 1'b1;
            validNext = 1'b0;
            stateNext = FETCH;
          end
        end
      end
      SUM: begin
        if (xfer) begin
          validNext = 1'b0;
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: frame model, table of
// register patterns, plus restart/reset/stall sequences.
module tb_regfile_dump_ctrl;
  import regfile_dbg_pkg::*;

  typedef struct {
    int         pattern;
    int         readyPct;
    bit         csumKnown;
    logic [7:0] expCsum;
    int         expDone;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        dumpStart = 1'b0;
  logic [3:0]  rdAddr;
  logic [15:0] rdData;
  logic        busy;
  logic        cpuStall;
  logic        done;
  logic [15:0] regs [16];

  regfile_dump_ctrl_if sbus();

  assign rdData = regs[rdAddr];

  always #5 CLK = ~CLK;

  regfile_dump_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .dump_start (dumpStart),
    .rd_addr    (rdAddr),
    .rd_data    (rdData),
    .stream     (sbus),
    .busy       (busy),
    .cpu_stall  (cpuStall),
    .done       (done)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] got [$];
  logic [7:0] expQ [$];
  int   doneCnt, doneCyc, holdErr, busyErr, firstValid;
  int   addrAt11;
  bit   wrPending;
  logic [15:0] wrVal;
  int   wrLandCyc;
  vec_t vecs [6];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected frame straight from the register contents.
  task automatic buildExpected();
    logic [7:0] x;
    x = 8'h00;
    expQ.delete();
    expQ.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(regs[i][15:8]);
      expQ.push_back(regs[i][7:0]);
      x = x ^ regs[i][15:8] ^ regs[i][7:0];
    end
    expQ.push_back(x);
  endtask

  task automatic loadPattern(input int p);
    for (int i = 0; i < 16; i++) begin
      case (p)
        0: regs[i] = 16'h0000;
        1: regs[i] = (i == 3) ? 16'hBEEF : 16'h0000;
        2: regs[i] = 16'h1100 + 16'(i);
        3: regs[i] = 16'hFFFF;
        4: regs[i] = (i == 15) ? 16'h8001 : 16'h0000;
        default: regs[i] = 16'($urandom);
      endcase
    end
  endtask

  task automatic startFrame(input int readyPct);
    @(posedge CLK);
    #1;
    sbus.out_ready = ($urandom_range(99) < readyPct);
    dumpStart = 1'b1;
  endtask

  task automatic capture(input int readyPct, input int budget,
                         input int exStart, input int exLen);
    logic       holding;
    logic [7:0] held;
    bit         doWrite;
    holding = 1'b0;
    held = 8'h00;
    got.delete();
    doneCnt = 0;
    doneCyc = -1;
    holdErr = 0;
    busyErr = 0;
    firstValid = -1;
    addrAt11 = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge CLK);
      if (holding && (sbus.out_valid !== 1'b1 ||
                      sbus.out_data !== held))
        holdErr++;
      if (sbus.out_valid === 1'b1 && firstValid < 0)
        firstValid = cyc;
      if (sbus.out_valid === 1'b1 && sbus.out_ready)
        got.push_back(sbus.out_data);
      holding = sbus.out_valid && !sbus.out_ready;
      held = sbus.out_data;
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (cpuStall !== busy) busyErr++;
      if (cyc >= 1 && doneCyc < 0 && busy !== 1'b1)
        busyErr++;
      if (doneCyc == cyc && busy !== 1'b0) busyErr++;
      if (cyc == 11) addrAt11 = int'(rdAddr);
      doWrite = wrPending && cyc >= 2 && !cpuStall;
      @(posedge CLK);
      #1;
      if (doWrite) begin
        regs[0] = wrVal;
        wrPending = 1'b0;
        wrLandCyc = cyc;
      end
      dumpStart = (cyc + 1 >= exStart) &&
                  (cyc + 1 < exStart + exLen);
      sbus.out_ready = ($urandom_range(99) < readyPct);
    end
    dumpStart = 1'b0;
  endtask

  task automatic checkFrame(input string tag,
                            input logic [7:0] expCsum,
                            input int expDone);
    int mism;
    int firstBad;
    logic [31:0] lastByte;
    mism = 0;
    firstBad = -1;
    check({tag, " len"}, got.size(), 34);
    for (int i = 0; i < 34 && i < got.size(); i++) begin
      if (got[i] !== expQ[i]) begin
        mism++;
        if (firstBad < 0) firstBad = i;
      end
    end
    if (firstBad >= 0)
      $display("  %s first bad byte %0d: %0h vs %0h",
               tag, firstBad, got[firstBad], expQ[firstBad]);
    check({tag, " bytes"}, mism, 0);
    lastByte = (got.size() == 34) ? {24'h0, got[33]} : 32'hFFFF_FFFF;
    check({tag, " csum"}, lastByte, {24'h0, expCsum});
    check({tag, " doneCnt"}, doneCnt, 1);
    check({tag, " hold"}, holdErr, 0);
    check({tag, " busy"}, busyErr, 0);
    if (expDone >= 0) begin
      check({tag, " doneCyc"}, doneCyc, expDone);
      check({tag, " hdrCyc"}, firstValid, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vld;
    int dn;
    vecs[0] = '{0, 100, 1'b1, 8'h00, 51};
    vecs[1] = '{1, 100, 1'b1, 8'h51, 51};
    vecs[2] = '{2,  50, 1'b1, 8'h00, -1};
    vecs[3] = '{3, 100, 1'b1, 8'h00, 51};
    vecs[4] = '{4, 100, 1'b1, 8'h81, 51};
    vecs[5] = '{5,  70, 1'b0, 8'h00, -1};
    wrPending = 1'b0;
    wrVal = 16'h0;
    wrLandCyc = -1;
    loadPattern(0);
    sbus.out_ready = 1'b1;

    @(negedge CLK);
    check("rst valid", {31'h0, sbus.out_valid}, 0);
    check("rst data", {24'h0, sbus.out_data}, 0);
    check("rst busy", {31'h0, busy}, 0);
    check("rst stall", {31'h0, cpuStall}, 0);
    check("rst done", {31'h0, done}, 0);
    check("rst addr", {28'h0, rdAddr}, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    for (int v = 0; v < 6; v++) begin
      loadPattern(vecs[v].pattern);
      startFrame(vecs[v].readyPct);
      buildExpected();
      capture(vecs[v].readyPct,
              (vecs[v].readyPct == 100) ? 60 : 400, 0, 0);
      checkFrame($sformatf("vec%0d", v),
                 vecs[v].csumKnown ? vecs[v].expCsum : expQ[33],
                 vecs[v].expDone);
      if (vecs[v].pattern == 1)
        check("vec1 addr3", addrAt11, 3);
    end

    // start held high mid-frame must not restart or queue
    loadPattern(2);
    startFrame(100);
    buildExpected();
    capture(100, 90, 6, 20);
    checkFrame("restart", expQ[33], 51);

    // reset mid-frame aborts with no done and no resume
    loadPattern(4);
    startFrame(100);
    @(posedge CLK);
    #1;
    dumpStart = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check("abort valid", {31'h0, sbus.out_valid}, 0);
    check("abort busy", {31'h0, busy}, 0);
    check("abort done", {31'h0, done}, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    vld = 0;
    dn = 0;
    repeat (60) begin
      @(negedge CLK);
      if (sbus.out_valid === 1'b1) vld++;
      if (done === 1'b1) dn++;
    end
    check("abort idle", vld, 0);
    check("abort nodone", dn, 0);
    startFrame(100);
    buildExpected();
    capture(100, 60, 0, 0);
    checkFrame("after rst", expQ[33], 51);

    // CPU write attempt during dump waits for stall to drop
    loadPattern(5);
    startFrame(100);
    buildExpected();
    wrVal = ~regs[0];
    wrPending = 1'b1;
    wrLandCyc = -1;
    capture(100, 70, 0, 0);
    checkFrame("stall", expQ[33], 51);
    check("stall wr", {16'h0, regs[0]}, {16'h0, wrVal});
    check("stall wrcyc", wrLandCyc, 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
